// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fifo_pkg
// Brief    : Shared constants and helpers for the fifo_syn read-side stream
//            stage (data width default, FIFO read latency, buffer depth).
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Default data width of fifo_syn data_out and the output stream
    localparam int c_DATA_WIDTH      = 32;
    // fifo_syn presents data_out exactly one cycle after rd_en
    localparam int c_FIFO_RD_LATENCY = 1;
    // Skid buffer depth: enough to absorb the read in flight when the
    // consumer stalls while still sustaining one word per cycle
    localparam int c_BUF_DEPTH       = 2;

    // Ceiling log2; returns 0 for values of 0 or 1
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_buf2.sv
`default_nettype none
// ============================================================================
// Module   : stream_buf2
// Brief    : Two-entry register buffer with push/pop, occupancy count and
//            registered head word. A push and a pop in the same cycle keep the
//            count unchanged and advance the head, so there is no bubble.
// Revision : 1.0 - initial release
// ============================================================================
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [1:0]            o_count,
    output logic [DATA_WIDTH-1:0] o_head_data
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_head;
    logic [1:0]            r_count;
    logic                  w_tail;

    // The tail slot sits count entries past the head (mod 2). The upstream
    // credit logic never pushes into a full buffer.
    assign w_tail      = r_head ^ r_count[0];
    assign o_count     = r_count;
    assign o_head_data = r_mem[r_head];

    // Storage, head pointer and occupancy; clear drops contents but keeps data regs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_clr) begin
            r_head   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[w_tail] <= i_push_data;
            end
            if (i_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_stream
// Brief    : Drains fifo_syn (1-cycle registered read) into a valid/ready
//            stream at full throughput, framing every PKT_LEN words with
//            m_last. Reads are issued only when the word is guaranteed a slot
//            in the 2-entry buffer, so stalls never lose data.
//            Timing: m_ready -> fifo_rd_en is a combinational path by design
//            (it lets a pop free a credit in the same cycle); budget it when
//            closing timing against the FIFO's rd_en input.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_cs,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    // Beat counter needs at least one bit even for single-word packets
    localparam int                  c_BEAT_W    = (clog2(PKT_LEN) < 1) ? 1 : clog2(PKT_LEN);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(PKT_LEN - 1);

    // One flag per cycle of FIFO read latency; the FIFO answers in one cycle
    logic [c_FIFO_RD_LATENCY-1:0] r_inflight;
    logic [c_BEAT_W-1:0]          r_beat;
    logic [1:0]                   w_count;
    logic [DATA_WIDTH-1:0]        w_head;
    logic                         w_pop;
    logic [2:0]                   w_level;
    logic                         w_room;

    assign w_pop = m_valid && m_ready;

    // Words already committed to the buffer (held plus arriving), less the
    // one leaving this cycle. A new read is allowed only if it still fits.
    assign w_level = {1'b0, w_count} + {2'b00, r_inflight[0]};
    assign w_room  = w_level < (3'(c_BUF_DEPTH) + {2'b00, w_pop});

    assign fifo_cs    = !rst;
    assign fifo_rd_en = !rst && !flush && !fifo_empty && w_room;

    assign m_valid = !rst && (w_count != 2'd0);
    assign m_data  = rst ? '0 : w_head;
    assign m_last  = m_valid && (r_beat == c_LAST_BEAT);

    // Buffer clear on flush outranks both the capture and the pop
    stream_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (flush),
        .i_push      (r_inflight[0]),
        .i_push_data (fifo_data),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head_data (w_head)
    );

    // Track the read issued this cycle; rd_en is low under flush, so an
    // in-flight word is never captured after a flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
        end
    end

    // Packet framing: count accepted words, wrap after the last beat
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_beat <= '0;
        end else if (w_pop) begin
            if (r_beat == c_LAST_BEAT) begin
                r_beat <= '0;
            end else begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
